// File: rtl/sf_window_scheduler_pkg.sv
// sf_pkg: shared FSM state type and default-configuration widths for sf_window_scheduler
package sf_pkg;
  typedef enum logic [2:0] {IDLE, ARB, COLLECT, EMIT, FIN} state_t;
  localparam int SHIFT = $clog2(4);
  localparam int CH_W = $clog2(4);
  localparam int WIN_W = $clog2(12 + 1);
  localparam int CNT_W = SHIFT;
  localparam int SUM_W = 8 + SHIFT;
endpackage

// File: rtl/sf_window_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible channel at/after ptr
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic              any_grant,
  output logic [CH_W-1:0]   idx
);
  // Scanning from the far end lets the nearest eligible channel overwrite later ones.
  always_comb begin
    any_grant = 1'b0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[(int'(ptr) + k) % NUM_CH]) begin
        any_grant = 1'b1;
        idx = CH_W'((int'(ptr) + k) % NUM_CH);
      end
    end
  end
  assign grant = any_grant ? (NUM_CH'(1) << idx) : '0;
endmodule

// File: rtl/sf_window_scheduler.sv
// sf_window_scheduler: round-robin time-shared window averager over NUM_CH sample streams
module sf_window_scheduler
  import sf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FILT_SIZE = 4,
  parameter int NUM_CH = 4,
  parameter int WIN_PER_CH = 12
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NUM_CH-1:0]                  req,
  input  logic [NUM_CH-1:0]                  s_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       s_data,
  output logic [NUM_CH-1:0]                  s_ready,
  output logic [NUM_CH-1:0]                  grant,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [DATA_WIDTH-1:0]              m_data,
  output logic [$clog2(NUM_CH)-1:0]          m_ch,
  output logic [$clog2(WIN_PER_CH+1)-1:0]    m_win,
  output logic                               busy,
  output logic                               done
);
  localparam int SHIFT = $clog2(FILT_SIZE);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int WIN_W = $clog2(WIN_PER_CH + 1);
  localparam int CNT_W = SHIFT;
  localparam int SUM_W = DATA_WIDTH + SHIFT;
  state_t state, nxt;
  logic [NUM_CH-1:0] grant_r, finished, eligible, arb_grant;
  logic arb_any, take, last;
  logic [CH_W-1:0] arb_idx, g_idx, ptr;
  logic [SUM_W-1:0] sum, sum_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIN_W-1:0] win_cnt [NUM_CH];
  logic [DATA_WIDTH-1:0] sample;
  always_comb begin
    finished = '0;
    for (int i = 0; i < NUM_CH; i++) finished[i] = win_cnt[i] == WIN_W'(WIN_PER_CH);
  end
  assign eligible = req & ~finished;
  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (arb_grant),
    .any_grant(arb_any),
    .idx      (arb_idx)
  );
  assign sample = s_data[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign take = state == COLLECT && s_valid[g_idx];
  assign last = cnt == CNT_W'(FILT_SIZE - 1);
  assign sum_nxt = sum + SUM_W'(sample);
  assign grant = grant_r;
  assign s_ready = state == COLLECT ? grant_r : '0;
  assign m_valid = state == EMIT;
  assign busy = state inside {ARB, COLLECT, EMIT};
  assign done = state == FIN;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ARB : IDLE;
      ARB:     nxt = &finished ? FIN : (arb_any ? COLLECT : ARB);
      COLLECT: nxt = take && last ? EMIT : COLLECT;
      EMIT:    nxt = m_ready ? ARB : EMIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant_r <= '0;
      g_idx <= '0;
      ptr <= '0;
      sum <= '0;
      cnt <= '0;
      m_data <= '0;
      m_ch <= '0;
      m_win <= '0;
      for (int i = 0; i < NUM_CH; i++) win_cnt[i] <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start)
        for (int i = 0; i < NUM_CH; i++) win_cnt[i] <= '0;
      if (state == ARB && !(&finished) && arb_any) begin
        grant_r <= arb_grant;
        g_idx <= arb_idx;
      end
      if (take) begin
        sum <= last ? '0 : sum_nxt;
        cnt <= last ? '0 : cnt + CNT_W'(1);
        if (last) begin
          m_data <= DATA_WIDTH'(sum_nxt >> SHIFT);
          m_ch <= g_idx;
          m_win <= win_cnt[g_idx];
        end
      end
      if (state == EMIT && m_ready) begin
        win_cnt[g_idx] <= win_cnt[g_idx] + WIN_W'(1);
        ptr <= g_idx == CH_W'(NUM_CH - 1) ? '0 : g_idx + CH_W'(1);
        grant_r <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sf_window_scheduler.sv
// tb_sf_window_scheduler: directed table-driven checks plus multi-cycle corner sequences
module tb_sf_window_scheduler;
  logic clk = 1'b0;
  logic rst_n, start, m_ready, m_valid, busy, done;
  logic [3:0] req, s_valid, s_ready, grant, m_win;
  logic [31:0] s_data;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int checks = 0, errors = 0;
  int win_model [4];
  typedef struct {
    int ch;
    logic [3:0][7:0] s;
    int bub;
    int avg;
  } vec_t;
  vec_t tv [6];

  sf_window_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .grant(grant), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_win(m_win),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_grant(input int ch);
    for (int t = 0; t < 20 && grant == 4'b0; t++) @(negedge clk);
    chk("grant", 32'(grant), 32'(4'b1 << ch));
  endtask

  task automatic run_window(input int ch, input logic [3:0][7:0] s, input int bub, input int avg);
    req = 4'b1 << ch;
    wait_grant(ch);
    for (int k = 0; k < 4; k++) begin
      if (bub != 0 && k == 2) begin
        s_valid = 4'b0;
        @(negedge clk);
        chk("bubble_no_valid", 32'(m_valid), 0);
      end
      s_valid = 4'b1 << ch;
      s_data[ch*8 +: 8] = s[k];
      @(negedge clk);
    end
    s_valid = 4'b0;
    chk("m_valid_latency", 32'(m_valid), 1);
    chk("m_data", 32'(m_data), 32'(avg));
    chk("m_ch", 32'(m_ch), 32'(ch));
    chk("m_win", 32'(m_win), 32'(win_model[ch]));
    chk("s_ready_emit", 32'(s_ready), 0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    req = 4'b0;
    win_model[ch]++;
  endtask

  initial begin
    int ndone, ch_e;
    logic [7:0] held;
    tv[0] = '{0, {8'd40, 8'd30, 8'd20, 8'd10}, 0, 25};
    tv[1] = '{2, {8'd2, 8'd1, 8'd1, 8'd1}, 0, 1};
    tv[2] = '{2, {8'd255, 8'd255, 8'd255, 8'd255}, 0, 255};
    tv[3] = '{1, {8'd3, 8'd0, 8'd0, 8'd0}, 1, 0};
    tv[4] = '{3, {8'd10, 8'd9, 8'd8, 8'd7}, 0, 8};
    tv[5] = '{0, {8'd103, 8'd102, 8'd101, 8'd100}, 1, 101};
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; req = 4'b0; s_valid = 4'b0; s_data = '0;
    for (int i = 0; i < 4; i++) win_model[i] = 0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    for (int v = 0; v < 6; v++) run_window(tv[v].ch, tv[v].s, tv[v].bub, tv[v].avg);
    // EMIT hold under backpressure, and ownership lock despite req changes
    req = 4'b0010;
    wait_grant(1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req = 4'b1000;
      s_valid = 4'b0010;
      s_data[15:8] = k < 2 ? 8'd4 : 8'd8;
      @(negedge clk);
    end
    s_valid = 4'b0;
    chk("lock_grant", 32'(grant), 32'(4'b0010));
    held = m_data;
    chk("lock_m_data", 32'(m_data), 6);
    for (int t = 0; t < 5; t++) begin
      chk("hold_m_valid", 32'(m_valid), 1);
      chk("hold_m_data", 32'(m_data), 32'(held));
      chk("hold_m_ch", 32'(m_ch), 1);
      chk("hold_s_ready", 32'(s_ready), 0);
      @(negedge clk);
    end
    chk("hold_m_win", 32'(m_win), 32'(win_model[1]));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    req = 4'b0;
    win_model[1]++;
    // asynchronous reset in the middle of a window
    req = 4'b0100;
    wait_grant(2);
    for (int k = 0; k < 2; k++) begin
      s_valid = 4'b0100;
      s_data[23:16] = 8'd50;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 0);
    chk("arst_s_ready", 32'(s_ready), 0);
    chk("arst_m_data", 32'(m_data), 0);
    chk("arst_m_ch", 32'(m_ch), 0);
    chk("arst_m_win", 32'(m_win), 0);
    chk("arst_busy", 32'(busy), 0);
    s_valid = 4'b0;
    req = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) win_model[i] = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_window(2, {8'd6, 8'd3, 8'd2, 8'd1}, 0, 3);
    // all channels requesting: round-robin starts just after ch2
    s_data = {8'd40, 8'd30, 8'd20, 8'd10};
    s_valid = 4'b1111;
    req = 4'b1111;
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int t = 0; t < 20 && !m_valid; t++) @(negedge clk);
      ch_e = (3 + k) % 4;
      chk("rr_m_ch", 32'(m_ch), 32'(ch_e));
      chk("rr_m_data", 32'(m_data), 32'(10 * (ch_e + 1)));
      chk("rr_m_win", 32'(m_win), 32'(win_model[ch_e]));
      chk("rr_onehot", 32'($countones(grant)), 1);
      win_model[ch_e]++;
      @(negedge clk);
    end
    // run the rest of the frame; a mid-frame start must not reset progress
    ndone = 0;
    for (int t = 0; t < 1000 && ndone == 0; t++) begin
      start = t == 20;
      if (m_valid) begin
        chk("frame_not_finished", 32'(win_model[m_ch] < 12), 1);
        chk("frame_m_win", 32'(m_win), 32'(win_model[m_ch]));
        win_model[m_ch]++;
      end
      if (done) ndone++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 32'(ndone), 1);
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
    for (int i = 0; i < 4; i++) chk("frame_windows", 32'(win_model[i]), 12);
    repeat (5) @(negedge clk);
    chk("idle_no_grant", 32'(grant), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
